pred_rf_multi: RTL



---
 rtl/pred_rf_pkg.sv | 26 ++
 rtl/pred_rf_send_stage.sv | 85 ++++++++
 rtl/pred_rf_multi.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pred_rf_pkg.sv
// Shared encodings for the predicate register file: FU select values, write-source priority, channel field extraction.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package pred_rf_pkg;

  localparam int FU_SEL_FILE      = 0;
  localparam int FU_SEL_EDGE_BASE = 1;
  localparam int MAX_P_W          = 32;
  localparam int MAX_BUS_W        = 1024;

  // Source that owns an address this cycle; WB outranks CAP on a same-address clash.
  typedef enum logic [1:0] {
    WR_SRC_NONE = 2'd0,
    WR_SRC_CAP  = 2'd1,
    WR_SRC_WB   = 2'd2
  } wr_src_e;

  function automatic int sel_to_edge(input int sel);
    return sel - FU_SEL_EDGE_BASE;
  endfunction

  function automatic logic [MAX_P_W-1:0] ch_field(input logic [MAX_BUS_W-1:0] bus,
                                                  input int ch, input int w);
    return MAX_P_W'(bus >> (ch * w));
  endfunction

endpackage

// File: rtl/pred_rf_send_stage.sv
// Send stage: write-first forward of the addressed entry, mask expansion, registered edge outputs and send_miss.
// Latency 1 cycle; no backpressure, a send is accepted every cycle.
module pred_rf_send_stage
  import pred_rf_pkg::*;
#(
  parameter int P_W    = 4,
  parameter int N_EDGE = 4,
  parameter int ADDR_W = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    send_en_i,
  input  logic [ADDR_W-1:0]       send_addr_i,
  input  logic [N_EDGE-1:0]       send_mask_i,
  input  logic [P_W-1:0]          rd_dat_i,
  input  logic                    rd_vld_i,
  input  logic                    flush_i,
  input  logic                    cap_we_i,
  input  logic [ADDR_W-1:0]       cap_addr_i,
  input  logic [P_W-1:0]          cap_dat_i,
  input  logic                    wb_en_i,
  input  logic [ADDR_W-1:0]       wb_addr_i,
  input  logic [P_W-1:0]          wb_dat_i,
  output logic [N_EDGE*P_W-1:0]   edge_p_out_o,
  output logic [N_EDGE-1:0]       edge_p_out_vld_o,
  output logic                    send_miss_o
);

  wr_src_e                 fwd_src;
  logic [P_W-1:0]          fwd_dat;
  logic                    fwd_vld;
  logic [N_EDGE*P_W-1:0]   out_dat_d, out_dat_q;
  logic [N_EDGE-1:0]       out_vld_d, out_vld_q;
  logic                    send_miss_d, send_miss_q;

  always_comb begin
    fwd_src = WR_SRC_NONE;
    if (cap_we_i && (cap_addr_i == send_addr_i)) fwd_src = WR_SRC_CAP;
    if (wb_en_i && (wb_addr_i == send_addr_i))   fwd_src = WR_SRC_WB;
  end

  // A flush with no same-address write leaves the entry invalid for this send.
  always_comb begin
    fwd_dat = rd_dat_i;
    fwd_vld = rd_vld_i && !flush_i;
    case (fwd_src)
      WR_SRC_WB: begin
        fwd_dat = wb_dat_i;
        fwd_vld = 1'b1;
      end
      WR_SRC_CAP: begin
        fwd_dat = cap_dat_i;
        fwd_vld = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_dat_d   = '0;
    out_vld_d   = '0;
    send_miss_d = send_en_i && !fwd_vld;
    for (int j = 0; j < N_EDGE; j++) begin
      out_vld_d[j] = send_en_i && send_mask_i[j] && fwd_vld;
      if (out_vld_d[j]) out_dat_d[j*P_W +: P_W] = fwd_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_dat_q   <= '0;
      out_vld_q   <= '0;
      send_miss_q <= 1'b0;
    end else begin
      out_dat_q   <= out_dat_d;
      out_vld_q   <= out_vld_d;
      send_miss_q <= send_miss_d;
    end
  end

  assign edge_p_out_o     = out_dat_q;
  assign edge_p_out_vld_o = out_vld_q;
  assign send_miss_o      = send_miss_q;

endmodule

// File: rtl/pred_rf_multi.sv
// Predicate register file for a CGRA PE: edge capture + FU write-back, FU read/bypass mux, masked edge send.
// FU path combinational, send and status 1 cycle; no backpressure, every operation completes in its cycle.
module pred_rf_multi
  import pred_rf_pkg::*;
#(
  parameter  int P_W    = 4,
  parameter  int DEPTH  = 64,
  parameter  int N_EDGE = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SEL_W  = $clog2(N_EDGE + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_EDGE*P_W-1:0] edge_p_in,
  input  logic [N_EDGE-1:0]     edge_p_in_vld,
  input  logic                  cap_en,
  input  logic [SEL_W-1:0]      cap_sel,
  input  logic [ADDR_W-1:0]     cap_addr,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [P_W-1:0]        wb_data,
  input  logic                  flush,
  input  logic [SEL_W-1:0]      fu_sel,
  input  logic [ADDR_W-1:0]     fu_addr,
  output logic [P_W-1:0]        pred_out,
  output logic                  pred_out_vld,
  input  logic                  send_en,
  input  logic [ADDR_W-1:0]     send_addr,
  input  logic [N_EDGE-1:0]     send_mask,
  output logic [N_EDGE*P_W-1:0] edge_p_out,
  output logic [N_EDGE-1:0]     edge_p_out_vld,
  output logic                  rd_miss,
  output logic                  send_miss,
  output logic                  wr_collide
);

  localparam logic [SEL_W-1:0] N_EDGE_SEL = SEL_W'(N_EDGE);
  localparam logic [SEL_W-1:0] SEL_FILE   = SEL_W'(FU_SEL_FILE);
  localparam int               VLD_EXT_W  = 2**SEL_W;

  logic [P_W-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic                 rd_miss_q, rd_miss_d;
  logic                 wr_collide_q, wr_collide_d;
  logic [VLD_EXT_W-1:0] edge_vld_ext;
  logic                 cap_ok, cap_we;
  logic [P_W-1:0]       cap_dat;

  // Zero-extended so any select value indexes safely; out-of-range channels read invalid.
  assign edge_vld_ext = VLD_EXT_W'(edge_p_in_vld);
  assign cap_ok       = cap_en && (cap_sel < N_EDGE_SEL) && edge_vld_ext[cap_sel];
  assign cap_dat      = P_W'(ch_field(MAX_BUS_W'(edge_p_in), int'(cap_sel), P_W));
  assign wr_collide_d = cap_ok && wb_en && (cap_addr == wb_addr);
  assign cap_we       = cap_ok && !wr_collide_d;

  always_comb begin
    valid_d = valid_q;
    if (flush)  valid_d = '0;
    if (cap_we) valid_d[cap_addr] = 1'b1;
    if (wb_en)  valid_d[wb_addr]  = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (cap_we) data_q[cap_addr] <= cap_dat;
      if (wb_en)  data_q[wb_addr]  <= wb_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q      <= '0;
      rd_miss_q    <= 1'b0;
      wr_collide_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rd_miss_q    <= rd_miss_d;
      wr_collide_q <= wr_collide_d;
    end
  end

  assign rd_miss_d = (fu_sel == SEL_FILE) && !valid_q[fu_addr];

  always_comb begin
    pred_out     = '0;
    pred_out_vld = 1'b0;
    if (fu_sel == SEL_FILE) begin
      pred_out_vld = valid_q[fu_addr];
      if (valid_q[fu_addr]) pred_out = data_q[fu_addr];
    end else if (fu_sel <= N_EDGE_SEL) begin
      pred_out     = P_W'(ch_field(MAX_BUS_W'(edge_p_in), sel_to_edge(int'(fu_sel)), P_W));
      pred_out_vld = edge_vld_ext[fu_sel - SEL_W'(1)];
    end
  end

  pred_rf_send_stage #(
    .P_W    (P_W),
    .N_EDGE (N_EDGE),
    .ADDR_W (ADDR_W)
  ) u_send (
    .clk_i            (CLK),
    .rst_i            (RST),
    .send_en_i        (send_en),
    .send_addr_i      (send_addr),
    .send_mask_i      (send_mask),
    .rd_dat_i         (data_q[send_addr]),
    .rd_vld_i         (valid_q[send_addr]),
    .flush_i          (flush),
    .cap_we_i         (cap_we),
    .cap_addr_i       (cap_addr),
    .cap_dat_i        (cap_dat),
    .wb_en_i          (wb_en),
    .wb_addr_i        (wb_addr),
    .wb_dat_i         (wb_data),
    .edge_p_out_o     (edge_p_out),
    .edge_p_out_vld_o (edge_p_out_vld),
    .send_miss_o      (send_miss)
  );

  assign rd_miss    = rd_miss_q;
  assign wr_collide = wr_collide_q;

endmodule
